// File: rtl/pa_soc_uart_tx_pkg.sv
// Shared definitions for the SoC UART transmitter: register offsets, frame FSM states, divisor default.
package pa_soc_uart_tx_pkg;

  localparam logic [1:0]  ADDR_TXDATA      = 2'd0;
  localparam logic [1:0]  ADDR_BAUDDIV     = 2'd1;
  localparam logic [1:0]  ADDR_PARCFG      = 2'd3;
  localparam logic [15:0] BAUD_DIV_DEFAULT = 16'd434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // A divisor of 0 or 1 would leave no room for the reload value, so floor it at 2.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/pa_soc_uart_fifo.sv
// Generic synchronous FIFO, 1-cycle push-to-visible latency, combinational head read.
// Push while full and pop while empty are ignored; pointers carry one extra wrap bit.
module pa_soc_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/pa_soc_uart_tx.sv
// Memory-mapped 8N1 UART transmitter (LSB first); PA_UART_TX_PARITY_EN adds a parity bit.
// Write-to-start-bit latency 2 edges; TXDATA writes into a full FIFO are dropped.
module pa_soc_uart_tx
  import pa_soc_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] BAUD_DIV_RST = BAUD_DIV_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [1:0]                    wr_addr_i,
  input  logic [31:0]                   wr_data_i,
  output logic                          txd_o,
  output logic                          tx_busy_o,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          irq_o
);
  tx_state_e   state_q, state_d;
  logic [15:0] div_q;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        push, pop, bit_done;
  logic [7:0]  head_dat;
  logic        unused_wr_hi;

  assign unused_wr_hi = ^wr_data_i[31:16];
  assign push         = wr_en_i && (wr_addr_i == ADDR_TXDATA);
  assign bit_done     = (baud_cnt_q == 16'd0);

  pa_soc_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (wr_data_i[7:0]),
    .pop_i      (pop),
    .pop_dat_o  (head_dat),
    .full_o     (fifo_full_o),
    .empty_o    (fifo_empty_o),
    .level_o    (fifo_level_o)
  );

`ifdef PA_UART_TX_PARITY_EN
  logic par_q, odd_q;

  // Parity is latched with the byte so a mode change mid-frame cannot corrupt it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      if (pop) par_q <= (^head_dat) ^ odd_q;
      if (wr_en_i && (wr_addr_i == ADDR_PARCFG)) odd_q <= wr_data_i[0];
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_done ? (div_q - 16'd1) : (baud_cnt_q - 16'd1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txd_d      = 1'b1;
        baud_cnt_d = div_q - 16'd1;
        if (!fifo_empty_o) begin
          pop     = 1'b1;
          shift_d = head_dat;
          state_d = ST_START;
          txd_d   = 1'b0;
        end
      end
      ST_START: if (bit_done) begin
        state_d   = ST_DATA;
        bit_cnt_d = 3'd0;
        txd_d     = shift_q[0];
      end
      ST_DATA: if (bit_done) begin
        if (bit_cnt_q == 3'd7) begin
`ifdef PA_UART_TX_PARITY_EN
          state_d = ST_PARITY;
          txd_d   = par_q;
`else
          state_d = ST_STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          txd_d     = shift_q[1];
        end
      end
`ifdef PA_UART_TX_PARITY_EN
      ST_PARITY: if (bit_done) begin
        state_d = ST_STOP;
        txd_d   = 1'b1;
      end
`endif
      // Back-to-back frames: a queued byte starts right after the stop bit.
      ST_STOP: if (bit_done) begin
        if (!fifo_empty_o) begin
          pop     = 1'b1;
          shift_d = head_dat;
          state_d = ST_START;
          txd_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      div_q      <= BAUD_DIV_RST;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      if (wr_en_i && (wr_addr_i == ADDR_BAUDDIV)) div_q <= clamp_div(wr_data_i[15:0]);
    end
  end

  assign txd_o     = txd_q;
  assign tx_busy_o = (state_q != ST_IDLE);
  assign irq_o     = fifo_empty_o & ~tx_busy_o;

endmodule

// File: tb/tb_pa_soc_uart_tx.sv
// Directed bench for pa_soc_uart_tx: frame decode, back-to-back, FIFO full, divisor change, reset abort.
// Build with PA_UART_TX_PARITY_EN to also exercise the parity bit.
module tb_pa_soc_uart_tx;

`ifdef PA_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wr_en_i;
  logic [1:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        txd_o, tx_busy_o, fifo_full_o, fifo_empty_o, irq_o;
  logic [3:0]  fifo_level_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_en;
  int          mon_div;
  logic [10:0] mon_f;
  logic [10:0] rx_q[$];
  int          busy_q[$];
  int          busy_run;
  int          n;

  pa_soc_uart_tx #(
    .FIFO_DEPTH   (8),
    .BAUD_DIV_RST (16'd434)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .txd_o        (txd_o),
    .tx_busy_o    (tx_busy_o),
    .fifo_full_o  (fifo_full_o),
    .fifo_empty_o (fifo_empty_o),
    .fifo_level_o (fifo_level_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_par(input logic [7:0] b, input logic odd);
    return {1'b1, (^b) ^ odd, b, 1'b0};
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef PA_UART_TX_PARITY_EN
    return frame_par(b, 1'b0);
`else
    return {2'b01, b, 1'b0};
`endif
  endfunction

  function automatic logic [10:0] pop_frame();
    if (rx_q.size() == 0) return 11'h7FF;
    return rx_q.pop_front();
  endfunction

  function automatic int pop_busy();
    if (busy_q.size() == 0) return -1;
    return busy_q.pop_front();
  endfunction

  // Called on a falling edge; the write lands on the following rising edge.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    @(negedge clk);
    wr_en_i   = 1'b0;
  endtask

  task automatic run_len(input logic v, input int budget, output int len);
    len = 0;
    while (txd_o == v && len < budget) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_frames(input int cnt, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < cnt && c < budget) begin
      c++;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_runs(input int cnt, input int budget);
    int c;
    c = 0;
    while (busy_q.size() < cnt && c < budget) begin
      c++;
      @(negedge clk);
    end
  endtask

  // Mid-bit sampling receiver.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd_o === 1'b0) begin
        mon_f = '0;
        repeat (mon_div / 2) @(negedge clk);
        mon_f[0] = txd_o;
        for (int k = 1; k < FB; k++) begin
          repeat (mon_div) @(negedge clk);
          mon_f[k] = txd_o;
        end
        rx_q.push_back(mon_f);
      end
    end
  end

  initial begin
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (tx_busy_o === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        busy_q.push_back(busy_run);
        busy_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = 2'd0; wr_data_i = 32'd0;
    mon_en = 1'b0; mon_div = 4;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("rst_txd", txd_o, 1'b1);
    check_eq("rst_busy", tx_busy_o, 1'b0);
    check_eq("rst_empty", fifo_empty_o, 1'b1);
    check_eq("rst_full", fifo_full_o, 1'b0);
    check_eq("rst_level", fifo_level_o, 4'd0);
    check_eq("rst_irq", irq_o, 1'b1);

    write_reg(2'd2, 32'h55);
    check_eq("addr2_level", fifo_level_o, 4'd0);
    write_reg(2'd1, 32'd4);
    repeat (2) @(negedge clk);
    check_eq("addr2_txd", txd_o, 1'b1);

    // Single 0x55 frame at divisor 4
    mon_div = 4; mon_en = 1'b1;
    rx_q.delete(); busy_q.delete();
    write_reg(2'd0, 32'h55);
    check_eq("t1_lat1_txd", txd_o, 1'b1);
    check_eq("t1_level", fifo_level_o, 4'd1);
    @(negedge clk);
    check_eq("t1_lat2_txd", txd_o, 1'b0);
    check_eq("t1_busy", tx_busy_o, 1'b1);
    check_eq("t1_irq_low", irq_o, 1'b0);
    wait_frames(1, 200);
    check_eq("t1_frame", pop_frame(), frame_of(8'h55));
    wait_busy_runs(1, 200);
    check_eq("t1_len", pop_busy(), FB * 4);
    check_eq("t1_irq_back", irq_o, 1'b1);

    // Back-to-back "ABC"
    rx_q.delete(); busy_q.delete();
    write_reg(2'd0, 32'h41);
    write_reg(2'd0, 32'h42);
    write_reg(2'd0, 32'h43);
    wait_frames(3, 600);
    check_eq("t2_A", pop_frame(), frame_of(8'h41));
    check_eq("t2_B", pop_frame(), frame_of(8'h42));
    check_eq("t2_C", pop_frame(), frame_of(8'h43));
    wait_busy_runs(1, 200);
    check_eq("t2_busy_len", pop_busy(), 3 * FB * 4);

    // FIFO fill at divisor 100, 10th byte dropped
    write_reg(2'd1, 32'd100);
    mon_div = 100;
    rx_q.delete(); busy_q.delete();
    for (int i = 0; i < 9; i++) write_reg(2'd0, 32'(i));
    check_eq("t3_full", fifo_full_o, 1'b1);
    check_eq("t3_level8", fifo_level_o, 4'd8);
    write_reg(2'd0, 32'h09);
    check_eq("t3_drop_level", fifo_level_o, 4'd8);
    check_eq("t3_drop_full", fifo_full_o, 1'b1);
    wait_frames(9, 12000);
    for (int i = 0; i < 9; i++) check_eq($sformatf("t3_byte%0d", i), pop_frame(), frame_of(8'(i)));
    wait_busy_runs(1, 1500);
    check_eq("t3_busy_len", pop_busy(), 9 * FB * 100);
    check_eq("t3_no_extra", rx_q.size(), 0);
    check_eq("t3_empty", fifo_empty_o, 1'b1);

    // Divisor change mid-DATA, then clamp of 1 to 2
    mon_en = 1'b0;
    write_reg(2'd1, 32'd4);
    write_reg(2'd0, 32'h55);
    @(negedge clk);
    run_len(1'b0, 50, n);
    check_eq("t4_start4", n, 4);
    write_reg(2'd1, 32'd8);
    run_len(1'b1, 50, n);
    check_eq("t4_d0_old", n + 1, 4);
    run_len(1'b0, 50, n);
    check_eq("t4_d1_new", n, 8);
    run_len(1'b1, 50, n);
    check_eq("t4_d2_new", n, 8);
    write_reg(2'd1, 32'd1);
    run_len(1'b0, 50, n);
    check_eq("t4_d3_old", n + 1, 8);
    run_len(1'b1, 50, n);
    check_eq("t4_d4_clamp", n, 2);
    run_len(1'b0, 50, n);
    check_eq("t4_d5_clamp", n, 2);
    repeat (40) @(negedge clk);
    check_eq("t4_idle", tx_busy_o, 1'b0);

`ifdef PA_UART_TX_PARITY_EN
    write_reg(2'd1, 32'd4);
    mon_div = 4; mon_en = 1'b1;
    rx_q.delete(); busy_q.delete();
    write_reg(2'd0, 32'h07);
    wait_frames(1, 200);
    check_eq("t6_even", pop_frame(), frame_par(8'h07, 1'b0));
    wait_busy_runs(1, 200);
    check_eq("t6_len", pop_busy(), 44);
    write_reg(2'd3, 32'd1);
    write_reg(2'd0, 32'h07);
    wait_frames(1, 200);
    check_eq("t6_odd", pop_frame(), frame_par(8'h07, 1'b1));
    mon_en = 1'b0;
    repeat (20) @(negedge clk);
`endif

    // Reset during data bit 3 of 0xA5 with two bytes queued
    write_reg(2'd1, 32'd4);
    write_reg(2'd0, 32'hA5);
    write_reg(2'd0, 32'h11);
    write_reg(2'd0, 32'h22);
    check_eq("t5_queued", fifo_level_o, 4'd2);
    repeat (16) @(negedge clk);
    check_eq("t5_bit3", txd_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("t5_txd", txd_o, 1'b1);
    check_eq("t5_level", fifo_level_o, 4'd0);
    check_eq("t5_busy", tx_busy_o, 1'b0);
    check_eq("t5_irq", irq_o, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd_o !== 1'b1 || tx_busy_o !== 1'b0) n++;
    end
    check_eq("t5_quiet", n, 0);
    write_reg(2'd0, 32'hFF);
    @(negedge clk);
    run_len(1'b0, 2000, n);
    check_eq("t5_div_rst", n, 434);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pa_soc_uart_tx.md
Name: pa_soc_uart_tx

Overview:
- Memory-mapped UART transmitter inside the SoC core.
- Drives the core's serial TXD pin, which the simulation UART monitor samples.
- CPU stores to the data register push bytes into a small TX FIFO.
- A baud-rate divider and a frame FSM serialise each byte as 8N1, LSB first.

Parameters:
- FIFO_DEPTH, 8: TX FIFO entries. Power of two, 2..16.
- BAUD_DIV_RST, 16'd434: reset value of the divisor (clk cycles per bit). 434 gives 115200 baud at 50 MHz.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  register write strobe, one cycle per write.
- wr_addr_i  in  2  register select: 0 = TXDATA, 1 = BAUDDIV, 2/3 = ignored.
- wr_data_i  in  32  write data. TXDATA uses [7:0]; BAUDDIV uses [15:0].
- txd_o  out  1  serial output, idle high.
- tx_busy_o  out  1  FSM not IDLE.
- fifo_full_o  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty_o  out  1  FIFO holds 0 entries.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- irq_o  out  1  transmit-complete level: fifo_empty_o & ~tx_busy_o.

Behaviour:
- Reset values:
  - txd_o=1, tx_busy_o=0, fifo_empty_o=1, fifo_full_o=0, fifo_level_o=0, irq_o=1.
  - Divisor = BAUD_DIV_RST.
  - FSM = IDLE; read/write pointers = 0.
  - Reset asserted mid-frame aborts the frame: txd_o returns to 1 on the next edge and FIFO contents are discarded.
- Registers:
  - A TXDATA write pushes wr_data_i[7:0] at the clock edge.
  - A push while full is dropped silently; level and pointers are unchanged.
  - A BAUDDIV write loads the divisor at the next edge. It takes effect at the next bit boundary; the current bit keeps its old length.
  - A divisor value below 2 is clamped to 2.
- FIFO:
  - Circular buffer with pointers one bit wider than the address. Wrap-around follows from the natural pointer overflow.
  - Push and pop in the same cycle while non-empty: level unchanged, both pointers advance.
  - Push into an empty FIFO while the FSM pops in the same cycle: not possible, because a pop requires non-empty in the previous cycle.
- Frame FSM states: IDLE -> START -> DATA -> STOP -> IDLE/START.
  - IDLE: if FIFO non-empty, pop the head into shift_reg, load baud counter = divisor-1, go to START, txd_o=0.
    - Latency from the TXDATA write edge (FIFO empty, FSM idle) to txd_o falling: 2 cycles (one edge to store, one edge to pop).
  - START: hold 0 for divisor cycles, then go to DATA with bit_cnt=0.
  - DATA: txd_o=shift_reg[0] for divisor cycles each. Shift right after each bit. After bit_cnt==7 finishes, go to STOP.
  - STOP: hold 1 for divisor cycles. Then:
    - FIFO non-empty: pop, go straight to START with no idle gap (back-to-back frames).
    - Otherwise: go to IDLE.
  - Baud counter counts down. The bit boundary is reached when the counter is 0; the counter then reloads divisor-1.
- Frame length: 10*divisor cycles; 11*divisor with parity enabled.
- txd_o is driven from a flop (glitch-free).
- tx_busy_o is high from the START entry edge through the last STOP cycle.

Optional Feature:
- Macro: PA_UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - Sends one bit = even parity (XOR of the 8 data bits) for divisor cycles.
  - wr_addr_i==3, bit 0 selects odd parity (1) or even (0); reset value 0.
- Undefined: no PARITY state; address 3 is ignored; frame is 8N1.

Decomposition:
- Shared package/include (pa_soc_param.v): register offset constants, FSM state encodings, BAUD_DIV_RST default.
- One natural sub-module: pa_soc_uart_fifo. It is a parameterised synchronous FIFO with push/pop/full/empty/level outputs, reusable for a future RX path.

Test Plan:
- Divisor 4; write 0x55 -> txd_o falls 2 cycles after the write. Bits sampled every 4 cycles read 0,1,0,1,0,1,0,1,0,1; frame lasts 40 cycles; irq_o returns to 1.
- Divisor 4; write 0x41, 0x42, 0x43 on consecutive cycles -> three frames with no idle gap between STOP and START. Monitor decodes "ABC"; tx_busy_o is high continuously for 120 cycles.
- Divisor 100 (slow drain); 9 writes of 0x00..0x08 while FIFO_DEPTH=8 and the FSM pops entry 0 after 2 cycles -> the 9th write is accepted, fifo_full_o asserts, and a 10th write (0x09) is dropped. Output stream is 0x00..0x08.
- Write BAUDDIV=8 while the frame at divisor 4 is mid-DATA -> the current bit stays 4 cycles and subsequent bits are 8 cycles. A later BAUDDIV=1 write gives 2-cycle bits (clamp).
- Assert rst_i during bit 3 of a 0xA5 frame with 2 bytes queued -> txd_o=1 next edge, fifo_level_o=0, no further frames, divisor back to 434.
- With PA_UART_TX_PARITY_EN and divisor 4: write 0x07 -> parity bit 1, frame 44 cycles. Set odd mode, write 0x07 -> parity bit 0.
